gpio_pad_bank: RTL
==================

// Module: gpio_pad_bank
// PURPOSE
//  Parametrised bidirectional GPIO bank between the SoC iomem bus and a row of bidirectional pad cells.
//  Generalises the fixed-direction pad hookup in the top level:
//  - per-channel runtime direction
//  - atomic set/clear
//  - 2-flop input synchronisation
//  - rise/fall edge capture with a combined interrupt
//  Instantiated once per pad group in the chip top; pad_o/pad_oe/pad_i wire straight to pad cells.
// PARAMETERS
//  NUM_IO          8    number of channels, legal 1..32; unused register bits read 0, writes ignored
//  DEBOUNCE_CYCLES 16   stable-input cycles required by the glitch filter (GPIO_DEBOUNCE_EN only), >=1
// PORTS
//  clk           in   1        system clock
//  resetn        in   1        asynchronous active-low reset
//  iomem_valid   in   1        bus request, pre-qualified by top-level address decode
//  iomem_ready   out  1        one-cycle completion pulse
//  iomem_wstrb   in   4        byte write strobes; 0 = read
//  iomem_addr    in   5        word-aligned offset; [4:2] selects register
//  iomem_wdata   in   32       write data
//  iomem_rdata   out  32       read data, valid while iomem_ready=1, else 0
//  pad_o         out  NUM_IO   output value to pads
//  pad_oe        out  NUM_IO   output enable to pads, 1 = drive
//  pad_i         in   NUM_IO   raw pad input, asynchronous
//  irq           out  1        OR of IRQ_PEND
// BEHAVIOUR
//  Register map (addr[4:2]):
//   0 DATA_OUT rw    1 DIR rw    2 DATA_IN ro    3 RISE_EN rw    4 FALL_EN rw
//   5 IRQ_PEND rw1c  6 SET wo (1 sets DATA_OUT bit)    7 CLR wo (1 clears DATA_OUT bit)
//  Bus handshake:
//   - iomem_ready asserts the cycle after iomem_valid is first seen, for exactly 1 cycle.
//   - Write takes effect on the same edge that raises ready.
//   - ready is never asserted on two consecutive cycles; a held valid starts a new access the cycle after ready drops.
//   - wstrb byte lanes are honoured on rw registers. SET/CLR/PEND act on enabled lanes only.
//   - Reads of write-only registers (6, 7) return 0.
//  Pad path:
//   - pad_o = DATA_OUT, pad_oe = DIR, both registered with no added latency.
//   - DATA_IN = synchronised (filtered) pad_i, regardless of DIR; loopback reads the driven value.
//   - Latency pad_i -> DATA_IN is 2 cycles (sync only).
//  Edge capture:
//   - Edges are compared on the synced/filtered value, against its previous-cycle copy.
//   - rise & RISE_EN, or fall & FALL_EN, sets the IRQ_PEND bit 1 cycle after DATA_IN changes.
//   - irq is registered from IRQ_PEND, so it rises 1 cycle after the PEND bit sets.
//   - Simultaneous edge set and W1C on the same bit: set wins, bit stays 1.
//   - Simultaneous SET and CLR is impossible (one register per access).
//  Reset (async assert, sync deassert handled at top):
//   - DATA_OUT, DIR, RISE_EN, FALL_EN, IRQ_PEND, sync flops, iomem_ready, iomem_rdata, irq all 0.
//   - All pads are inputs after reset.
//   - Edge detection is masked for the first 3 cycles after resetn rises, so a pad already high never sets PEND.
//  Reset mid-access: the access is dropped; no ready is issued for it.
// CONFIGURATION
//  GPIO_DEBOUNCE_EN defined:
//   - per-channel counter, width $clog2(DEBOUNCE_CYCLES+1), after the sync flops.
//   - Filtered value adopts the synced value only after DEBOUNCE_CYCLES consecutive equal samples.
//   - The counter restarts on any change.
//   - Latency is 2+DEBOUNCE_CYCLES cycles; edge mask extends to DEBOUNCE_CYCLES+3.
//  Undefined: no filter logic; filtered = synced; latency 2.
// STRUCTURE
//  gpio_pkg:
//   - register offset localparams (GPIO_DATA_OUT..GPIO_CLR)
//   - NUM_IO_MAX=32
//   - register-index typedef
//  Sub-module gpio_sync_filter:
//   - one channel: 2-flop sync, optional debounce, edge pulses
//   - instantiated NUM_IO times in a generate loop
//  Top holds bus FSM (IDLE -> ACK -> IDLE), registers, IRQ logic.
// TESTING
//  1 Reset with pad_i=8'hFF -> pad_oe=0, DATA_IN reads 8'hFF after 2 cycles, IRQ_PEND=0, irq=0.
//  2 Write DIR=8'h0F, DATA_OUT=8'hA5 -> pad_oe=8'h0F, pad_o=8'hA5.
//    Then SET 8'h02 gives DATA_OUT=8'hA7; CLR 8'h81 gives 8'h26.
//  3 RISE_EN=8'h01, pad_i[0] 0->1:
//    - IRQ_PEND=8'h01 3 cycles after the pad edge, irq 1 cycle later.
//    - W1C 8'h01 then clears it; irq=0 the following cycle.
//  4 FALL_EN=8'h10, pad_i[4] falls in the cycle a W1C of 8'h10 is written -> IRQ_PEND[4] remains 1.
//  5 Write with wstrb=4'b0001 of 32'hFFFF_FF00 to DATA_OUT=8'h00 -> DATA_OUT stays 8'h00.
//    NUM_IO=8 read of DIR returns 0 in bits [31:8]. Every access returns exactly one ready pulse.
//  6 GPIO_DEBOUNCE_EN, DEBOUNCE_CYCLES=4:
//    - a 3-cycle high glitch on pad_i[1] leaves DATA_IN unchanged.
//    - a 6-cycle high pulse updates DATA_IN[1] 6 cycles after the edge.

Source files
------------

// File: rtl/gpio_pkg.sv
// gpio_pkg: register offsets, register index and bus state types shared by the GPIO bank
package gpio_pkg;
  localparam int NUM_IO_MAX = 32;
  localparam logic [4:0] GPIO_DATA_OUT = 5'h00;
  localparam logic [4:0] GPIO_DIR      = 5'h04;
  localparam logic [4:0] GPIO_DATA_IN  = 5'h08;
  localparam logic [4:0] GPIO_RISE_EN  = 5'h0C;
  localparam logic [4:0] GPIO_FALL_EN  = 5'h10;
  localparam logic [4:0] GPIO_IRQ_PEND = 5'h14;
  localparam logic [4:0] GPIO_SET      = 5'h18;
  localparam logic [4:0] GPIO_CLR      = 5'h1C;
  typedef enum logic [2:0] {
    IDX_DATA_OUT = GPIO_DATA_OUT[4:2],
    IDX_DIR      = GPIO_DIR[4:2],
    IDX_DATA_IN  = GPIO_DATA_IN[4:2],
    IDX_RISE_EN  = GPIO_RISE_EN[4:2],
    IDX_FALL_EN  = GPIO_FALL_EN[4:2],
    IDX_IRQ_PEND = GPIO_IRQ_PEND[4:2],
    IDX_SET      = GPIO_SET[4:2],
    IDX_CLR      = GPIO_CLR[4:2]
  } reg_idx_t;
  typedef enum logic {IDLE, ACK} bus_state_t;
endpackage

// File: rtl/gpio_sync_filter.sv
// gpio_sync_filter: one pad input, 2-flop sync, optional GPIO_DEBOUNCE_EN glitch filter, edge pulses
module gpio_sync_filter
`ifdef GPIO_DEBOUNCE_EN
#(
  parameter int DEBOUNCE_CYCLES = 16
)
`endif
(
  input  logic clk,
  input  logic resetn,
  input  logic pad_i,
  output logic filt,
  output logic rise,
  output logic fall
);
  logic s1, s2, prev;
  // synchroniser pair plus last-cycle copy of the filtered value for edge detection
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {s1, s2, prev} <= '0;
    else {s1, s2, prev} <= {pad_i, s1, filt};
`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1);
  // count consecutive samples that disagree with the filtered value; adopt on the last one
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt  <= '0;
      filt <= 1'b0;
    end else begin
      cnt  <= s2 == filt || done ? '0 : cnt + 1'b1;
      filt <= s2 != filt && done ? s2 : filt;
    end
`else
  assign filt = s2;
`endif
  assign rise = filt & ~prev;
  assign fall = ~filt & prev;
endmodule

// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: iomem GPIO bank with direction, set/clear, edge IRQs; GPIO_DEBOUNCE_EN adds input debounce
module gpio_pad_bank
  import gpio_pkg::*;
#(
  parameter int NUM_IO          = 8,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [4:0]        iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  output logic [NUM_IO-1:0] pad_o,
  output logic [NUM_IO-1:0] pad_oe,
  input  logic [NUM_IO-1:0] pad_i,
  output logic              irq
);
`ifdef GPIO_DEBOUNCE_EN
  localparam int MASK_CYCLES = DEBOUNCE_CYCLES + 3;
`else
  localparam int MASK_CYCLES = 3;
`endif
  localparam int MW = $clog2(DEBOUNCE_CYCLES + 4);
  bus_state_t st, st_d;
  reg_idx_t sel;
  logic [NUM_IO-1:0] data_out, dir, rise_en, fall_en, pend, filt, rise, fall, wm, wd, ev;
  logic [31:0] bm;
  logic [NUM_IO_MAX-1:0] rd_val;
  logic [MW-1:0] mask_cnt;
  logic acc, wr, unused_bits;
  assign sel         = reg_idx_t'(iomem_addr[4:2]);
  assign acc         = st == IDLE && iomem_valid;
  assign wr          = acc && |iomem_wstrb;
  assign bm          = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wm          = bm[NUM_IO-1:0];
  assign wd          = iomem_wdata[NUM_IO-1:0] & wm;
  assign ev          = mask_cnt == MW'(MASK_CYCLES) ? (rise & rise_en) | (fall & fall_en) : '0;
  assign iomem_ready = st == ACK;
  assign pad_o       = data_out;
  assign pad_oe      = dir;
  assign unused_bits = ^{iomem_addr[1:0], iomem_wdata, bm};
  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    gpio_sync_filter
`ifdef GPIO_DEBOUNCE_EN
      #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES))
`endif
      u_ch (
        .clk   (clk),
        .resetn(resetn),
        .pad_i (pad_i[i]),
        .filt  (filt[i]),
        .rise  (rise[i]),
        .fall  (fall[i])
      );
  end
  // a seen request moves to ACK for exactly one cycle, then back to IDLE
  always_comb st_d = acc ? ACK : IDLE;
  // read mux, zero-extended so unused channel bits read 0
  always_comb begin
    rd_val = '0;
    rd_val[NUM_IO-1:0] = sel == IDX_DATA_OUT ? data_out :
                         sel == IDX_DIR      ? dir      :
                         sel == IDX_DATA_IN  ? filt     :
                         sel == IDX_RISE_EN  ? rise_en  :
                         sel == IDX_FALL_EN  ? fall_en  :
                         sel == IDX_IRQ_PEND ? pend     : '0;
  end
  // bus state register
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) st <= IDLE;
    else st <= st_d;
  // writable registers; an edge event on the same cycle as its W1C keeps the pending bit set
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      data_out <= '0;
      dir      <= '0;
      rise_en  <= '0;
      fall_en  <= '0;
      pend     <= '0;
    end else begin
      data_out <= !wr                ? data_out :
                  sel == IDX_DATA_OUT ? (data_out & ~wm) | wd :
                  sel == IDX_SET      ? data_out | wd :
                  sel == IDX_CLR      ? data_out & ~wd : data_out;
      dir      <= wr && sel == IDX_DIR     ? (dir & ~wm) | wd : dir;
      rise_en  <= wr && sel == IDX_RISE_EN ? (rise_en & ~wm) | wd : rise_en;
      fall_en  <= wr && sel == IDX_FALL_EN ? (fall_en & ~wm) | wd : fall_en;
      pend     <= (pend & ~(wr && sel == IDX_IRQ_PEND ? wd : '0)) | ev;
    end
  // read data, registered irq and the post-reset edge mask counter
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      iomem_rdata <= '0;
      irq         <= 1'b0;
      mask_cnt    <= '0;
    end else begin
      iomem_rdata <= acc && !(|iomem_wstrb) ? 32'(rd_val) : '0;
      irq         <= |pend;
      mask_cnt    <= mask_cnt == MW'(MASK_CYCLES) ? mask_cnt : mask_cnt + 1'b1;
    end
endmodule
